nmic_cmd_responder: RTL and testbench
=====================================

# nmic_cmd_responder

Single-lane NMIC-side responder for the controller↔NMIC serial command link. It deserializes 32-bit command frames arriving on one `c2n_data`/`c2n_vld` lane and executes them against a local register file. Each response is serialized on `n2c_data` during the following frame. One instance serves one lane; two instances model both lanes of the 2-bit bus, as a bench model and as the basis for an on-FPGA NMIC emulator.

## Interface
- `NREG`, 16: register file depth (≤64; address field is 6 bits).
- `ID`, 16'h4E4D: value returned by the ID command.
- `clk`  in  1: link clock; all logic on rising edge.
- `rstb`  in  1: synchronous, active-low reset.
- `c2n_data`  in  1: command bit, MSB first, valid when `c2n_vld`=1.
- `c2n_vld`  in  1: frame qualifier, high for 32 consecutive cycles per frame.
- `n2c_data`  out  1: response bit, aligned to `c2n_vld`.
- `cmd_strobe`  out  1: one-cycle pulse per accepted frame.
- `cmd_op`  out  2: op of the last accepted frame.
- `cmd_addr`  out  6: address of the last accepted frame.
- `frame_err`  out  1: one-cycle pulse on an aborted frame.
- `regs`  out  NREG*16: flattened register file; reg k is at [16k+15:16k].

## Operation
- Command word fields:
  - [31:30] op: 00 NOP, 01 READ, 10 WRITE, 11 ID.
  - [29:24] addr.
  - [23:16] reserved; ignored.
  - [15:0] wdata.
- Receive:
  - `bitcnt` (5 bits) counts `c2n_vld` cycles.
  - `rx_sr` shifts in `c2n_data` LSB-side.
  - Completion is the edge where `c2n_vld`=1 and `bitcnt`=31. The full word is {rx_sr[30:0], c2n_data}, decoded at that same edge. `bitcnt` wraps to 0.
- Execute, at the completion edge:
  - WRITE with addr<NREG: reg[addr] ← wdata.
  - WRITE with addr≥NREG: write is dropped.
  - READ/NOP/ID: no register state changes.
- Response word, loaded into `tx_sr` at the completion edge:
  - NOP: 32'h0.
  - READ: {01, addr, err, 7'h0, reg[addr]}. The data is the pre-edge value. If addr≥NREG, data is 16'h0.
  - WRITE: {10, addr, err, 7'h0, wdata}.
  - ID: {11, 6'h3F, 8'h0, ID}.
  - err = (addr≥NREG), for READ/WRITE only.
- Transmit:
  - `n2c_data` = `c2n_vld` ? `tx_sr[31]` : 0.
  - `tx_sr` shifts left, zero-filling, on each `c2n_vld` cycle that is not a completion edge.
- Abort:
  - Trigger: `c2n_vld`=0 while `bitcnt`≠0.
  - At that edge: `bitcnt` ← 0, `rx_sr` ← 0, `tx_sr` ← 0, `frame_err` pulses the next cycle.
  - No execute, no `cmd_strobe`, register file untouched.
- Back-to-back frames: `c2n_vld` may stay high indefinitely. Bit 0 of frame N+1 follows bit 31 of frame N with no gap, and `tx_sr` already holds response N.
- Idle: with `c2n_vld`=0 and `bitcnt`=0, all state holds and `tx_sr` keeps the pending response across any gap length.

## Timing
- Reset (`rstb`=0 at an edge): all of the following are 0 the next cycle and persist while reset is held:
  - `bitcnt`, `rx_sr`, `tx_sr`
  - `n2c_data`, `cmd_strobe`, `cmd_op`, `cmd_addr`, `frame_err`
  - all regs
- Reset mid-frame: the partial frame is discarded, no `frame_err`, and the first post-reset frame starts at bit 0.
- Response latency: exactly one frame. The response to frame N appears on `n2c_data` during the 32 `c2n_vld` cycles of frame N+1, MSB first. The first frame after reset returns all zeros.
- `cmd_strobe`, `cmd_op`, `cmd_addr` are registered and update in the cycle after the completion edge. `cmd_op` and `cmd_addr` hold until the next completion.
- The register write and `regs` update are visible the cycle after the completion edge.
- Simultaneous READ and WRITE to the same address cannot occur (one command per frame). A READ in frame N+1 of the address written in frame N returns the new value.

## Test plan
- WRITE 0x8300_BEEF (addr 3), then READ 0x4300_0000, then NOP:
  - Frame 2 `n2c_data` = 0x8300_BEEF.
  - Frame 3 `n2c_data` = 0x4300_BEEF.
  - `regs`[63:48] = 16'hBEEF.
  - `cmd_strobe` pulses ×3.
- Back-to-back, `c2n_vld` held high for 96 cycles: ID, NOP, NOP.
  - Frame 2 returns 0xFF00_4E4D.
  - No gaps; `bitcnt` wraps correctly.
- Abort: 20 bits of WRITE to addr 1 with value 0x1234, then `c2n_vld` low.
  - `frame_err` = 1 for one cycle.
  - reg1 remains 0.
  - The next frame returns 0x0000_0000.
- Out of range, NREG=16: WRITE addr 0x20 with 0x5555, then READ addr 0x20.
  - Responses are 0xA080_5555 and 0x6080_0000.
  - `regs` unchanged.
- Reset mid-frame: `rstb`=0 at bit 10 of a WRITE.
  - All outputs 0 and no write.
  - A subsequent full READ of addr 0 returns 0x4000_0000 in the following frame.
- Idle gap: WRITE addr 2 with 0x00A5, then 100 idle cycles, then NOP.
  - `n2c_data` = 0 throughout the idle gap.
  - The NOP frame carries 0x8200_00A5.

Source files
------------

// File: rtl/nmic_cmd_responder_if.sv
// Lane-side signal bundle between a controller model and the NMIC command responder.
// The master modport drives the command lane; the slave modport is the responder.
interface nmic_cmd_responder_if #(
    parameter int unsigned NREG = 16
);
    logic                 c2n_data;
    logic                 c2n_vld;
    logic                 n2c_data;
    logic                 cmd_strobe;
    logic [1:0]           cmd_op;
    logic [5:0]           cmd_addr;
    logic                 frame_err;
    logic [NREG*16-1:0]   regs;

    modport master (
        output c2n_data, c2n_vld,
        input  n2c_data, cmd_strobe, cmd_op, cmd_addr, frame_err, regs
    );

    modport slave (
        input  c2n_data, c2n_vld,
        output n2c_data, cmd_strobe, cmd_op, cmd_addr, frame_err, regs
    );
endinterface

// File: rtl/nmic_cmd_responder.sv
// Single-lane NMIC responder: deserializes 32-bit command frames, executes them against a
// local register file and serializes each response during the following frame.
module nmic_cmd_responder #(
    parameter int unsigned NREG = 16,
    parameter logic [15:0] ID   = 16'h4E4D
) (
    input  logic                  clk,
    input  logic                  rstb,
    nmic_cmd_responder_if.slave   bus
);
    localparam logic [1:0] OpNop   = 2'b00;
    localparam logic [1:0] OpRead  = 2'b01;
    localparam logic [1:0] OpWrite = 2'b10;
    localparam logic [1:0] OpId    = 2'b11;

    logic [4:0]  bitcnt_q, bitcnt_d;
    logic [31:0] rx_sr_q, rx_sr_d;
    logic [31:0] tx_sr_q, tx_sr_d;
    logic        cmd_strobe_q;
    logic [1:0]  cmd_op_q;
    logic [5:0]  cmd_addr_q;
    logic        frame_err_q;
    logic [15:0] regs_q [NREG];

    logic [31:0] word;
    logic [1:0]  op;
    logic [5:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rd_data;
    logic        in_range;
    logic        complete;
    logic        abort;
    logic [31:0] rsp;

    // Full word includes the bit arriving on the completion edge itself.
    assign word     = {rx_sr_q[30:0], bus.c2n_data};
    assign op       = word[31:30];
    assign addr     = word[29:24];
    assign wdata    = word[15:0];
    assign in_range = 32'(addr) < NREG;
    assign complete = bus.c2n_vld && (bitcnt_q == 5'd31);
    assign abort    = !bus.c2n_vld && (bitcnt_q != 5'd0);

    always_comb begin
        rd_data = 16'h0;
        for (int k = 0; k < int'(NREG); k++) begin
            if (addr == 6'(k)) rd_data = regs_q[k];
        end
    end

    always_comb begin
        rsp = 32'h0;
        unique case (op)
            OpNop:   rsp = 32'h0;
            OpRead:  rsp = {OpRead, addr, !in_range, 7'h0, rd_data};
            OpWrite: rsp = {OpWrite, addr, !in_range, 7'h0, wdata};
            OpId:    rsp = {OpId, 6'h3F, 8'h0, ID};
            default: rsp = 32'h0;
        endcase
    end

    always_comb begin
        bitcnt_d = bitcnt_q;
        rx_sr_d  = rx_sr_q;
        tx_sr_d  = tx_sr_q;
        if (bus.c2n_vld) begin
            bitcnt_d = bitcnt_q + 5'd1;
            rx_sr_d  = word;
            tx_sr_d  = complete ? rsp : {tx_sr_q[30:0], 1'b0};
        end else if (abort) begin
            bitcnt_d = 5'd0;
            rx_sr_d  = 32'h0;
            tx_sr_d  = 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            bitcnt_q     <= 5'd0;
            rx_sr_q      <= 32'h0;
            tx_sr_q      <= 32'h0;
            cmd_strobe_q <= 1'b0;
            cmd_op_q     <= 2'b00;
            cmd_addr_q   <= 6'h0;
            frame_err_q  <= 1'b0;
            for (int k = 0; k < int'(NREG); k++) regs_q[k] <= 16'h0;
        end else begin
            bitcnt_q     <= bitcnt_d;
            rx_sr_q      <= rx_sr_d;
            tx_sr_q      <= tx_sr_d;
            cmd_strobe_q <= complete;
            frame_err_q  <= abort;
            if (complete) begin
                cmd_op_q   <= op;
                cmd_addr_q <= addr;
                // Out-of-range writes match no index and are dropped.
                for (int k = 0; k < int'(NREG); k++) begin
                    if (op == OpWrite && addr == 6'(k)) regs_q[k] <= wdata;
                end
            end
        end
    end

    assign bus.n2c_data   = bus.c2n_vld ? tx_sr_q[31] : 1'b0;
    assign bus.cmd_strobe = cmd_strobe_q;
    assign bus.cmd_op     = cmd_op_q;
    assign bus.cmd_addr   = cmd_addr_q;
    assign bus.frame_err  = frame_err_q;

    for (genvar k = 0; k < int'(NREG); k++) begin : g_regs
        assign bus.regs[16*k +: 16] = regs_q[k];
    end
endmodule

// File: tb/tb_nmic_cmd_responder.sv
// Scoreboard bench: the driver pushes expected responses/commands from a behavioural model,
// a negedge monitor reassembles n2c_data frames and strobes and compares them.
module tb_nmic_cmd_responder;
    localparam int unsigned NREG = 16;
    localparam logic [15:0] IDV  = 16'h4E4D;

    logic clk = 1'b0;
    logic rstb = 1'b0;
    always #5 clk = ~clk;

    nmic_cmd_responder_if #(.NREG(NREG)) bus ();
    nmic_cmd_responder #(.NREG(NREG), .ID(IDV)) dut (.clk(clk), .rstb(rstb), .bus(bus));

    int errors = 0;
    int checks = 0;
    logic [31:0] rsp_q [$];
    logic [7:0]  cmd_q [$];
    logic [15:0] mreg [NREG];
    logic [31:0] pending;
    int exp_ferr = 0;
    int ferr_seen = 0;
    int strobe_seen = 0;
    int mcnt = 0;
    logic [31:0] msr = 32'h0;

    task automatic check(input string name, input logic [NREG*16-1:0] got,
                         input logic [NREG*16-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [NREG*16-1:0] mpack();
        logic [NREG*16-1:0] r;
        for (int k = 0; k < int'(NREG); k++) r[16*k +: 16] = mreg[k];
        return r;
    endfunction

    function automatic void mreset();
        for (int k = 0; k < int'(NREG); k++) mreg[k] = 16'h0;
        pending = 32'h0;
    endfunction

    // Reference: the command word's meaning, computed directly from its fields.
    function automatic logic [31:0] model_exec(input logic [31:0] w);
        logic [1:0]  op   = w[31:30];
        logic [5:0]  addr = w[29:24];
        logic [15:0] wd   = w[15:0];
        logic        oor  = addr >= 6'(NREG);
        logic [15:0] rd   = oor ? 16'h0 : mreg[addr[3:0]];
        case (op)
            2'd0: return 32'h0;
            2'd1: return {2'b01, addr, oor, 7'h0, rd};
            2'd2: begin
                if (!oor) mreg[addr[3:0]] = wd;
                return {2'b10, addr, oor, 7'h0, wd};
            end
            default: return {2'b11, 6'h3F, 8'h0, IDV};
        endcase
    endfunction

    task automatic drive_bit(input logic b);
        bus.c2n_vld  = 1'b1;
        bus.c2n_data = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        rsp_q.push_back(pending);
        cmd_q.push_back(w[31:24]);
        pending = model_exec(w);
        for (int i = 31; i >= 0; i--) drive_bit(w[i]);
    endtask

    task automatic idle(input int n);
        logic seen_hi = 1'b0;
        bus.c2n_vld  = 1'b0;
        bus.c2n_data = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.n2c_data !== 1'b0) seen_hi = 1'b1;
            @(posedge clk);
            #1;
        end
        check("idle_n2c_low", NREG*16'(seen_hi), '0);
    endtask

    task automatic send_abort(input logic [31:0] w, input int nbits);
        for (int i = 31; i > 31 - nbits; i--) drive_bit(w[i]);
        pending = 32'h0;
        exp_ferr++;
        idle(2);
    endtask

    always @(negedge clk) begin
        if (!rstb) begin
            mcnt = 0;
        end else if (bus.c2n_vld) begin
            msr = {msr[30:0], bus.n2c_data};
            mcnt++;
            if (mcnt == 32) begin
                mcnt = 0;
                if (rsp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got %08h expected none", msr);
                end else begin
                    check("rsp", NREG*16'(msr), NREG*16'(rsp_q.pop_front()));
                end
            end
        end else begin
            mcnt = 0;
        end
        if (rstb && bus.cmd_strobe) begin
            strobe_seen++;
            if (cmd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL strobe_unexpected: got op=%0d addr=%0h expected none",
                         bus.cmd_op, bus.cmd_addr);
            end else begin
                check("cmd_op_addr", NREG*16'({bus.cmd_op, bus.cmd_addr}),
                      NREG*16'(cmd_q.pop_front()));
            end
        end
        if (rstb && bus.frame_err) ferr_seen++;
    end

    task automatic check_all_zero(input string tag);
        @(negedge clk);
        check({tag, "_n2c"}, NREG*16'(bus.n2c_data), '0);
        check({tag, "_strobe"}, NREG*16'(bus.cmd_strobe), '0);
        check({tag, "_op"}, NREG*16'(bus.cmd_op), '0);
        check({tag, "_addr"}, NREG*16'(bus.cmd_addr), '0);
        check({tag, "_ferr"}, NREG*16'(bus.frame_err), '0);
        check({tag, "_regs"}, bus.regs, '0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int s0, f0;
        logic [31:0] w;
        bus.c2n_vld  = 1'b0;
        bus.c2n_data = 1'b0;
        mreset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rstb = 1'b1;

        // Write, read back, NOP.
        s0 = strobe_seen;
        send(32'h8300_BEEF);
        send(32'h4300_0000);
        send(32'h0000_0000);
        idle(2);
        check("reg3_beef", NREG*16'(bus.regs[63:48]), NREG*16'(16'hBEEF));
        check("strobe_x3", NREG*16'(strobe_seen - s0), NREG*16'(3));

        // Back-to-back ID, NOP, NOP then an abort with c2n_vld still high beforehand.
        send(32'hC000_0000);
        send(32'h0000_0000);
        send(32'h0000_0000);
        f0 = ferr_seen;
        send_abort(32'h8100_1234, 20);
        check("abort_ferr_once", NREG*16'(ferr_seen - f0), NREG*16'(1));
        check("abort_reg1", NREG*16'(bus.regs[31:16]), '0);
        send(32'h0000_0000);

        // Out-of-range write/read.
        send(32'hA000_5555);
        send(32'h6000_0000);
        send(32'h0000_0000);
        idle(1);
        check("oor_regs", bus.regs, mpack());

        // Reset in the middle of a write.
        for (int i = 31; i > 21; i--) drive_bit(32'h8500_7777 >> i);
        rstb = 1'b0;
        bus.c2n_vld = 1'b0;
        @(posedge clk);
        #1;
        mreset();
        check_all_zero("midrst");
        rstb = 1'b1;
        send(32'h4000_0000);
        send(32'h0000_0000);

        // Long idle gap keeps the pending response.
        send(32'h8200_00A5);
        idle(100);
        send(32'h0000_0000);
        idle(2);

        for (int n = 0; n < 80; n++) begin
            int r = int'($urandom_range(0, 9));
            w = {2'($urandom_range(0, 3)), 6'($urandom_range(0, 23)), 8'($urandom),
                 16'($urandom)};
            if (r == 0) send_abort(w, int'($urandom_range(1, 31)));
            else send(w);
            if (r < 3) idle(int'($urandom_range(1, 4)));
        end
        send(32'h0000_0000);
        idle(3);

        check("rsp_q_drained", NREG*16'(rsp_q.size()), '0);
        check("cmd_q_drained", NREG*16'(cmd_q.size()), '0);
        check("ferr_count", NREG*16'(ferr_seen), NREG*16'(exp_ferr));
        check("final_regs", bus.regs, mpack());
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
